// File: rtl/adder_wide_pkg.sv
// adder_wide_pkg
//   Shared definitions for the sequential wide adder:
//   - state_t   : FSM state encoding (IDLE/RUN/DONE)
//   - WORD_W    : width of one datapath word (the adder32 width)
//   - cnt_width : word-counter width for a given NWORDS, never below 1 bit
package adder_wide_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int nwords);
    return (nwords <= 1) ? 1 : $clog2(nwords);
  endfunction

endpackage

// File: rtl/adder_wide_seq_if.sv
// adder_wide_seq_if
//   Request/response bundle of the sequential wide adder.
//   Request : in_valid, in_ready, opa, opb, ci (and sub when ADDER_WIDE_SUB_EN)
//   Response: out_valid, out_ready, sum, co
//   master = issuing/consuming side, slave = the adder.
//   Macro ADDER_WIDE_SUB_EN adds the 1-bit sub request field.
interface adder_wide_seq_if
  import adder_wide_pkg::*;
#(
  parameter int NWORDS = 4
);
  localparam int W = WORD_W * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         ci;
`ifdef ADDER_WIDE_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;

`ifdef ADDER_WIDE_SUB_EN
  modport master (
    output in_valid, opa, opb, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co
  );
  modport slave (
    input  in_valid, opa, opb, ci, sub, out_ready,
    output in_ready, out_valid, sum, co
  );
`else
  modport master (
    output in_valid, opa, opb, ci, out_ready,
    input  in_ready, out_valid, sum, co
  );
  modport slave (
    input  in_valid, opa, opb, ci, out_ready,
    output in_ready, out_valid, sum, co
  );
`endif

endinterface

// File: rtl/adder_wide_seq_adder32.sv
// adder32
//   32-bit carry-select adder, purely combinational.
//   a, b : operands      ci : carry-in
//   s    : sum           co : carry-out of bit 31
//   The low half ripples; the high half is precomputed for both possible
//   carries out of the low half and selected by the real one.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [16:0] lo;
  logic [16:0] hi0;
  logic [16:0] hi1;

  assign lo  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + {16'd0, ci};
  assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
  assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

  assign s  = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
  assign co = lo[16] ? hi1[16] : hi0[16];

endmodule

// File: rtl/adder_wide_seq.sv
// adder_wide_seq
//   Multi-cycle W-bit adder (W = 32*NWORDS) that reuses one adder32 for
//   every word, LSW first, chaining the carry through a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : adder_wide_seq_if.slave (request/response handshakes, operands,
//           registered sum/co). NWORDS must match the interface instance.
//   Macro ADDER_WIDE_SUB_EN: adds bus.sub; sub=1 computes opa - opb with co
//   as the no-borrow flag.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for in_valid; captures operands on accept
//   RUN   | one word per cycle through adder32, cnt selects the word
//   DONE  | out_valid=1, result held until out_ready
module adder_wide_seq
  import adder_wide_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_wide_seq_if.slave   bus
);

  localparam int W  = WORD_W * NWORDS;
  localparam int CW = cnt_width(NWORDS);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  state_t            state;
  logic [W-1:0]      opa_q;
  logic [W-1:0]      opb_q;
  logic [W-1:0]      sum_q;
  logic [CW-1:0]     cnt;
  logic              carry_q;
  logic              co_q;
  logic              out_valid_q;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] s_word;
  logic              c_word;

  assign a_word = opa_q[cnt*WORD_W +: WORD_W];
  assign b_word = opb_q[cnt*WORD_W +: WORD_W];

  adder32 u_adder32 (
    .a  (a_word),
    .b  (b_word),
    .ci (carry_q),
    .s  (s_word),
    .co (c_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      cnt         <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            opa_q <= bus.opa;
`ifdef ADDER_WIDE_SUB_EN
            // Subtract as A + ~B + 1; ci is not used in that mode.
            opb_q   <= bus.sub ? ~bus.opb : bus.opb;
            carry_q <= bus.sub ? 1'b1 : bus.ci;
`else
            opb_q   <= bus.opb;
            carry_q <= bus.ci;
`endif
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[cnt*WORD_W +: WORD_W] <= s_word;
          carry_q                     <= c_word;
          if (cnt == LAST) begin
            co_q        <= c_word;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;

endmodule
